fibo_majority_stream: RTL and testbench

Streaming, parametrised Fibonacci-majority voter. It accepts a frame of COUNT unsigned WIDTH-bit samples over a valid/ready handshake and tests each sample for Fibonacci membership. It then reports whether a strict majority holds, either over all samples (flat mode) or over groups of three (hierarchical mode). It is the sequential, frame-based successor to the team's fixed 13-input combinational majority checker, and sits between a sample source and a result consumer.

---
 rtl/fibo_majority_stream.sv | 162 ++++++++++++++++
 tb/tb_fibo_majority_stream.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fibo_majority_stream.sv
// fibo_majority_stream
//   Frame-based Fibonacci-majority voter. Accepts COUNT unsigned WIDTH-bit
//   samples over valid/ready. It tests each sample for Fibonacci membership
//   and reports a strict-majority verdict in one of two modes:
//     flat:         over all samples.
//     hierarchical: over consecutive groups of three samples.
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     flush                synchronous frame abort (highest priority after reset)
//     mode                 0 = flat, 1 = hierarchical; latched on a frame's first accept
//     in_valid/in_ready    sample handshake, in_data = sample
//     out_valid/out_ready  result handshake
//     out_major            strict-majority verdict
//     out_hits             Fibonacci samples (flat) or true groups (hierarchical)
//     out_mode             mode used for the reported frame
module fibo_majority_stream #(
  parameter int WIDTH = 4,
  parameter int COUNT = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_major,
  output logic [7:0]       out_hits,
  output logic             out_mode
);

  localparam int GROUPS = (COUNT + 2) / 3;

  typedef enum logic [1:0] {IDLE, COLLECT, RESULT} state_t;

  state_t     state, state_nx;
  logic [7:0] idx;
  logic [1:0] gpos;
  logic [1:0] gfib;
  logic [7:0] hits;
  logic       mode_q;

  logic       accept;
  logic       is_fib;
  logic       cur_mode;
  logic       last;
  logic       grp_end;
  logic       grp_true;
  logic [1:0] gfib_nx;
  logic [7:0] hits_nx;
  logic       major_nx;

  // Walks the Fibonacci sequence far enough to cover any 16-bit value.
  // Terms above 2^WIDTH-1 can never match, so truncation is implicit.
  function automatic logic fib_member(input logic [WIDTH-1:0] v);
    logic [16:0] a;
    logic [16:0] b;
    logic [16:0] t;
    logic        hit;
    hit = 1'b0;
    a   = 17'd0;
    b   = 17'd1;
    for (int unsigned i = 0; i < 25; i++) begin
      if (a == 17'(v)) hit = 1'b1;
      t = a + b;
      a = b;
      b = t;
    end
    return hit;
  endfunction

  assign in_ready  = (state != RESULT);
  assign out_valid = (state == RESULT);
  assign accept    = in_valid && in_ready && !flush;
  assign is_fib    = fib_member(in_data);

  // The first sample of a frame uses the live mode input; later samples use the latched copy.
  assign cur_mode  = (state == IDLE) ? mode : mode_q;
  assign last      = (idx == 8'(COUNT - 1));
  assign grp_end   = (gpos == 2'd2) || last;

  always_comb begin
    gfib_nx = gfib;
    if (is_fib && gfib != 2'd2) gfib_nx = gfib + 2'd1;
  end

  // Single-sample groups need one hit. Two- and three-sample groups need two.
  // The count saturates at 2, so ">= 2" is the same as "== 2".
  assign grp_true = (gpos == 2'd0) ? (gfib_nx != 2'd0) : (gfib_nx == 2'd2);

  always_comb begin
    hits_nx = hits;
    if (cur_mode) begin
      if (grp_end && grp_true) hits_nx = hits + 8'd1;
    end else if (is_fib) begin
      hits_nx = hits + 8'd1;
    end
    if (cur_mode) major_nx = ({1'b0, hits_nx, 1'b0} > 10'(GROUPS));
    else          major_nx = ({1'b0, hits_nx, 1'b0} > 10'(COUNT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nx = last ? RESULT : COLLECT;
        COLLECT: if (accept && last) state_nx = RESULT;
        RESULT:  if (out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      gpos      <= '0;
      gfib      <= '0;
      hits      <= '0;
      mode_q    <= 1'b0;
      out_major <= 1'b0;
      out_hits  <= '0;
      out_mode  <= 1'b0;
    end else if (flush) begin
      idx       <= '0;
      gpos      <= '0;
      gfib      <= '0;
      hits      <= '0;
      mode_q    <= 1'b0;
      out_major <= 1'b0;
      out_hits  <= '0;
      out_mode  <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) mode_q <= mode;
      if (last) begin
        idx       <= '0;
        gpos      <= '0;
        gfib      <= '0;
        hits      <= '0;
        out_major <= major_nx;
        out_hits  <= hits_nx;
        out_mode  <= cur_mode;
      end else begin
        idx  <= idx + 8'd1;
        gpos <= grp_end ? 2'd0 : gpos + 2'd1;
        gfib <= grp_end ? 2'd0 : gfib_nx;
        hits <= hits_nx;
      end
    end
  end

endmodule

// File: tb/tb_fibo_majority_stream.sv
module tb_fibo_majority_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       flush = 1'b0;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_major;
  logic [7:0] out_hits;
  logic       out_mode;

  logic       b_flush = 1'b0;
  logic       b_mode = 1'b0;
  logic       b_in_valid = 1'b0;
  logic [7:0] b_in_data = '0;
  logic       b_in_ready;
  logic       b_out_valid;
  logic       b_out_ready = 1'b1;
  logic       b_out_major;
  logic [7:0] b_out_hits;
  logic       b_out_mode;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  fibo_majority_stream #(.WIDTH(4), .COUNT(13)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_major(out_major),
    .out_hits(out_hits), .out_mode(out_mode)
  );

  fibo_majority_stream #(.WIDTH(8), .COUNT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .mode(b_mode),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_major(b_out_major),
    .out_hits(b_out_hits), .out_mode(b_out_mode)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: generate the Fibonacci sequence up to 2^w-1 and search it.
  function automatic bit ref_fib(input int unsigned v, input int unsigned w);
    int unsigned a;
    int unsigned b;
    int unsigned t;
    int unsigned lim;
    a = 0;
    b = 1;
    lim = (1 << w) - 1;
    while (a <= lim) begin
      if (a == v) return 1'b1;
      t = a + b;
      a = b;
      b = t;
    end
    return 1'b0;
  endfunction

  function automatic void ref_frame(input int unsigned s[$], input bit m, input int unsigned w,
                                    output int unsigned hits, output bit major);
    int unsigned n;
    int unsigned groups;
    int unsigned sz;
    int unsigned k;
    n = s.size();
    hits = 0;
    groups = (n + 2) / 3;
    if (!m) begin
      foreach (s[i]) if (ref_fib(s[i], w)) hits++;
      major = (2 * hits > n);
    end else begin
      for (int unsigned g = 0; g < groups; g++) begin
        sz = (n - 3 * g >= 3) ? 3 : n - 3 * g;
        k = 0;
        for (int unsigned j = 0; j < sz; j++) if (ref_fib(s[3 * g + j], w)) k++;
        if ((sz == 3 && k >= 2) || (sz == 2 && k == 2) || (sz == 1 && k == 1)) hits++;
      end
      major = (2 * hits > groups);
    end
  endfunction

  // Drives samples back to back. With toggle set, mode flips after the first sample.
  task automatic send1(input int unsigned s[$], input bit m, input bit toggle);
    foreach (s[i]) begin
      in_valid = 1'b1;
      in_data  = 4'(s[i]);
      mode     = (toggle && i > 0) ? ~m : m;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic expect1(input string tag, input int unsigned s[$], input bit m);
    int unsigned eh;
    bit          em;
    ref_frame(s, m, 4, eh, em);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_hits"}, out_hits, eh);
    check({tag, "_major"}, out_major, em);
    check({tag, "_mode"}, out_mode, m);
    check({tag, "_inrdy_lo"}, in_ready, 0);
  endtask

  task automatic consume1(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_valid_clr"}, out_valid, 0);
    check({tag, "_inrdy_hi"}, in_ready, 1);
  endtask

  task automatic frame2(input string tag, input int unsigned s[$], input bit m);
    int unsigned eh;
    bit          em;
    ref_frame(s, m, 8, eh, em);
    foreach (s[i]) begin
      b_in_valid = 1'b1;
      b_in_data  = 8'(s[i]);
      b_mode     = m;
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    check({tag, "_valid"}, b_out_valid, 1);
    check({tag, "_hits"}, b_out_hits, eh);
    check({tag, "_major"}, b_out_major, em);
    check({tag, "_mode"}, b_out_mode, m);
    @(posedge clk); #1;
    check({tag, "_valid_clr"}, b_out_valid, 0);
  endtask

  function automatic int unsigned rnd_sample(input int unsigned w);
    int unsigned fl[13];
    int unsigned lim;
    int unsigned v;
    fl = '{0, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    lim = (w == 4) ? 6 : 12;
    if ($urandom_range(0, 1) == 1) v = fl[$urandom_range(0, lim)];
    else v = $urandom_range(0, (1 << w) - 1);
    return v;
  endfunction

  initial begin
    int unsigned q[$];
    int unsigned eh;
    bit          em;
    bit          m;

    #1 rst_n = 1'b0;
    #1;
    check("rst_inrdy", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_major", out_major, 0);
    check("rst_hits", out_hits, 0);
    check("rst_mode", out_mode, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    q = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    send1(q, 0, 0);
    expect1("all5", q, 0);
    check("all5_hits_lit", out_hits, 13);
    consume1("all5");

    q = '{1, 2, 4, 6, 7, 3, 9, 10, 13, 11, 12, 14, 0};
    send1(q, 0, 0);
    expect1("mix", q, 0);
    check("mix_hits_lit", out_hits, 5);
    consume1("mix");

    q = '{8, 8, 8, 8, 8, 8, 8, 4, 4, 4, 4, 4, 4};
    send1(q, 0, 0);
    expect1("eights", q, 0);
    consume1("eights");

    q = '{1, 2, 4, 3, 5, 6, 8, 13, 7, 4, 6, 7, 9};
    send1(q, 1, 0);
    expect1("hier", q, 1);
    check("hier_hits_lit", out_hits, 3);
    consume1("hier");
    send1(q, 0, 0);
    expect1("hierflat", q, 0);
    check("hierflat_hits_lit", out_hits, 6);
    consume1("hierflat");

    // Backpressure: the result must hold and a pending sample must be refused.
    q.delete();
    for (int i = 0; i < 13; i++) q.push_back(rnd_sample(4));
    ref_frame(q, 1, 4, eh, em);
    out_ready = 1'b0;
    send1(q, 1, 0);
    in_valid = 1'b1;
    in_data  = 4'd5;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_hits", out_hits, eh);
      check("bp_major", out_major, em);
      check("bp_inrdy", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    consume1("bp");
    q = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 0};
    send1(q, 0, 0);
    expect1("after_bp", q, 0);
    consume1("after_bp");

    // Asynchronous reset mid-frame.
    q = '{8, 8, 8, 8, 8, 8, 8};
    send1(q, 0, 0);
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_inrdy", in_ready, 1);
    check("arst_hits", out_hits, 0);
    check("arst_major", out_major, 0);
    check("arst_mode", out_mode, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    q = '{4, 6, 7, 9, 10, 11, 12, 14, 4, 6, 7, 1, 2};
    send1(q, 0, 0);
    expect1("post_rst", q, 0);
    consume1("post_rst");

    // Flush mid-frame drops the partial frame and the sample presented with it.
    q = '{5, 5, 5, 5};
    send1(q, 0, 0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'd13;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_inrdy", in_ready, 1);
    q = '{1, 4, 4, 4, 4, 4, 3, 5, 4, 2, 8, 13, 4};
    send1(q, 1, 1);
    expect1("latch", q, 1);
    consume1("latch");

    // Flush while a result is pending discards it.
    out_ready = 1'b0;
    send1(q, 0, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b1;
    check("flush_res_valid", out_valid, 0);
    check("flush_res_inrdy", in_ready, 1);

    // Randomized frames.
    for (int f = 0; f < 24; f++) begin
      q.delete();
      for (int i = 0; i < 13; i++) q.push_back(rnd_sample(4));
      m = 1'($urandom_range(0, 1));
      send1(q, m, 1'($urandom_range(0, 1)));
      expect1("rnd", q, m);
      consume1("rnd");
    end

    // Second instance: COUNT = 2 (trailing group of two), WIDTH = 8.
    q = '{5, 4};
    frame2("c2_54", q, 1);
    check("c2_54_hits_lit", b_out_hits, 0);
    q = '{144, 233};
    frame2("c2_big", q, 1);
    for (int f = 0; f < 16; f++) begin
      q = '{rnd_sample(8), rnd_sample(8)};
      frame2("c2_rnd", q, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
